// File: rtl/apb_master_bridge.sv
// Command/response to APB3 completer bridge: one outstanding transfer, IDLE/SETUP/ACCESS/RESP FSM.
// Optional access-phase timeout: define APB_MASTER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // Command and response channels: a transfer happens on an edge where valid && ready;
    // valid never waits on ready, and payload is held stable while valid is high.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        busy_out,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;

    // TIMEOUT_CYCLES must be at least 1; an empty block keeps the parameter referenced.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy_out  = (state != IDLE);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_write ? cmd_wdata : 32'h0;
                        state  <= SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        state     <= RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    // Count-th consecutive wait state ends the transfer with an error.
                    else if (wait_cnt == WAIT_LAST) begin
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset, write, waited read, error hold, back-to-back, reset abort, stall.
module tb_apb_master_bridge;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr, busy_out;
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_rd;
    int acc_cycles;

    apb_master_bridge #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .busy_out(busy_out), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called on a negedge with the bridge idle; returns on the negedge of the SETUP cycle.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_v);
        chk1("pre_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        exp_q.push_back(exp_v);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; prdata = 32'h5555_5555; pready = 1'b1; pslverr = 1'b0;

        // reset state
        tick();
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_busy", busy_out, 1'b0);
        chk1("rst_psel", psel, 1'b0);
        chk1("rst_penable", penable, 1'b0);
        chk1("rst_pwrite", pwrite, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("rel_cmd_ready", cmd_ready, 1'b1);

        // zero-wait write
        issue(1'b1, 32'h0, 32'h1, 32'h0);
        chk1("wr_setup_psel", psel, 1'b1);
        chk1("wr_setup_penable", penable, 1'b0);
        chk1("wr_setup_pwrite", pwrite, 1'b1);
        chk("wr_setup_paddr", paddr, 32'h0);
        chk("wr_setup_pwdata", pwdata, 32'h1);
        chk1("wr_setup_cmd_ready", cmd_ready, 1'b0);
        chk1("wr_setup_busy", busy_out, 1'b1);
        tick();
        chk1("wr_access_psel", psel, 1'b1);
        chk1("wr_access_penable", penable, 1'b1);
        tick();
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_rdata", rsp_rdata, exp_q.pop_front());
        chk1("wr_rsp_err", rsp_err, 1'b0);
        chk1("wr_rsp_psel", psel, 1'b0);
        tick();
        chk1("wr_idle_rsp_valid", rsp_valid, 1'b0);
        chk1("wr_idle_cmd_ready", cmd_ready, 1'b1);
        chk("wr_idle_pwdata_kept", pwdata, 32'h1);

        // read with three wait states; PRDATA/PSLVERR ignored while PREADY low
        pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
        issue(1'b0, 32'h8, 32'h1111_1111, 32'h00AB_CDEF);
        chk("rd_setup_paddr", paddr, 32'h8);
        chk("rd_setup_pwdata", pwdata, 32'h0);
        chk1("rd_setup_pwrite", pwrite, 1'b0);
        tick();
        chk1("rd_access_penable", penable, 1'b1);
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk1("rd_wait_penable", penable, 1'b1);
        end
        pready = 1'b1; prdata = 32'h00AB_CDEF; pslverr = 1'b0;
        tick();
        chk1("rd_rsp_valid_n6", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, exp_q.pop_front());
        chk1("rd_rsp_err", rsp_err, 1'b0);
        tick();

        // slave error, response held with rsp_ready low; cmd_* and PRDATA noise ignored
        rsp_ready = 1'b0; prdata = 32'h1234_5678; pslverr = 1'b1;
        issue(1'b0, 32'h10, 32'h0, 32'h1234_5678);
        tick();
        tick();
        exp_rd = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk1("err_hold_valid", rsp_valid, 1'b1);
            chk("err_hold_rdata", rsp_rdata, exp_rd);
            chk1("err_hold_err", rsp_err, 1'b1);
            chk1("err_hold_cmd_ready", cmd_ready, 1'b0);
            cmd_valid = 1'b1; cmd_addr = $urandom; prdata = $urandom; pslverr = 1'b0;
            tick();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        chk1("err_last_valid", rsp_valid, 1'b1);
        tick();
        chk1("err_done_valid", rsp_valid, 1'b0);
        chk1("err_done_cmd_ready", cmd_ready, 1'b1);
        chk("err_done_paddr", paddr, 32'h10);

        // back-to-back with cmd_valid held high
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0BAD_F00D;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hA5A5_A5A5;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0BAD_F00D);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) begin
                chk("b2b_first_paddr", paddr, 32'h20);
                chk("b2b_first_pwdata", pwdata, 32'hA5A5_A5A5);
                cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wdata = 32'h99;
            end
            chk1("b2b_first_cmd_ready", cmd_ready, 1'b0);
        end
        chk("b2b_first_rdata", rsp_rdata, exp_q.pop_front());
        tick();
        chk1("b2b_second_accept_n4", cmd_ready, 1'b1);
        @(posedge clk);
        tick();
        cmd_valid = 1'b0;
        chk1("b2b_second_psel", psel, 1'b1);
        chk1("b2b_second_penable", penable, 1'b0);
        chk("b2b_second_paddr", paddr, 32'h24);
        chk("b2b_second_pwdata", pwdata, 32'h0);
        tick();
        tick();
        chk1("b2b_second_valid", rsp_valid, 1'b1);
        chk("b2b_second_rdata", rsp_rdata, exp_q.pop_front());
        tick();

        // reset during ACCESS aborts without a response
        pready = 1'b0;
        issue(1'b1, 32'h30, 32'h77, 32'h0);
        tick();
        chk1("abort_pre_penable", penable, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("abort_psel", psel, 1'b0);
        chk1("abort_penable", penable, 1'b0);
        chk1("abort_busy", busy_out, 1'b0);
        chk("abort_paddr", paddr, 32'h0);
        exp_q.delete();
        pready = 1'b1;
        tick();
        tick();
        chk1("abort_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("abort_rel_cmd_ready", cmd_ready, 1'b1);
        chk1("abort_rel_rsp_valid", rsp_valid, 1'b0);
        prdata = 32'hCAFE_0001;
        issue(1'b0, 32'h40, 32'h0, 32'hCAFE_0001);
        chk("post_abort_paddr", paddr, 32'h40);
        tick();
        tick();
        chk1("post_abort_valid", rsp_valid, 1'b1);
        chk("post_abort_rdata", rsp_rdata, exp_q.pop_front());
        chk1("post_abort_err", rsp_err, 1'b0);
        tick();

        // completer stuck with PREADY low
        pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
        issue(1'b0, 32'h50, 32'h0, 32'h0);
        acc_cycles = 0;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            tick();
            if (psel && penable) acc_cycles++;
            else break;
        end
        chk("timeout_access_cycles", 32'(acc_cycles), 32'(TIMEOUT_CYCLES));
        chk1("timeout_psel", psel, 1'b0);
        chk1("timeout_rsp_valid", rsp_valid, 1'b1);
        chk1("timeout_rsp_err", rsp_err, 1'b1);
        chk("timeout_rsp_rdata", rsp_rdata, exp_q.pop_front());
        tick();
`else
        for (int k = 0; k < 120; k++) begin
            tick();
            if (psel && penable) acc_cycles++;
        end
        chk("stall_access_cycles", 32'(acc_cycles), 32'd120);
        chk1("stall_rsp_valid", rsp_valid, 1'b0);
        exp_q.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif
        chk1("end_cmd_ready", cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
